core_alu_arb: RTL

CORE_ALU_ARB -- requirements
Module: core_alu_arb

---
 rtl/core_alu_arb_pkg.sv | 42 ++++
 rtl/core_alu.sv | 36 +++
 rtl/core_alu_arb.sv | 90 +++++++++
 3 files changed

// File: rtl/core_alu_arb_pkg.sv
// Shared ALU word/function types, function codes and compare result codes.
// Imported by the ALU and the two-port ALU arbiter.
package core_alu_arb_pkg;

  localparam int WORD_W  = 32;
  localparam int FUNC_W  = 4;
  localparam int SHAMT_W = $clog2(WORD_W);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [FUNC_W-1:0] func_t;

  localparam func_t ALU_ADD  = 4'd0;
  localparam func_t ALU_SUB  = 4'd1;
  localparam func_t ALU_AND  = 4'd2;
  localparam func_t ALU_OR   = 4'd3;
  localparam func_t ALU_XOR  = 4'd4;
  localparam func_t ALU_SLL  = 4'd5;
  localparam func_t ALU_SRL  = 4'd6;
  localparam func_t ALU_SRA  = 4'd7;
  localparam func_t ALU_SLT  = 4'd8;
  localparam func_t ALU_SLTU = 4'd9;
  localparam func_t ALU_CMP  = 4'd10;
  localparam func_t ALU_CMPU = 4'd11;

  localparam logic  ALU_ENABLE  = 1'b1;
  localparam logic  ALU_DISABLE = 1'b0;
  localparam word_t ZERO_WORD   = '0;

  localparam word_t CMP_LT = 32'd1;
  localparam word_t CMP_EQ = 32'd2;
  localparam word_t CMP_GT = 32'd4;

  // Three-way compare; is_signed selects two's-complement ordering.
  function automatic word_t cmp3(input word_t a, input word_t b, input logic is_signed);
    logic lt;
    lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    if (a == b)  return CMP_EQ;
    else if (lt) return CMP_LT;
    else         return CMP_GT;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU; output forced to zero whenever evaluation is disabled.
module core_alu
  import core_alu_arb_pkg::*;
(
  input  logic  en,
  input  func_t func,
  input  word_t op1,
  input  word_t op2,
  output word_t result
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    result = ZERO_WORD;
    if (en == ALU_ENABLE) begin
      case (func)
        ALU_ADD:  result = op1 + op2;
        ALU_SUB:  result = op1 - op2;
        ALU_AND:  result = op1 & op2;
        ALU_OR:   result = op1 | op2;
        ALU_XOR:  result = op1 ^ op2;
        ALU_SLL:  result = op1 << shamt;
        ALU_SRL:  result = op1 >> shamt;
        ALU_SRA:  result = word_t'($signed(op1) >>> shamt);
        ALU_SLT:  result = {{(WORD_W-1){1'b0}}, $signed(op1) < $signed(op2)};
        ALU_SLTU: result = {{(WORD_W-1){1'b0}}, op1 < op2};
        ALU_CMP:  result = cmp3(op1, op2, 1'b1);
        ALU_CMPU: result = cmp3(op1, op2, 1'b0);
        default:  result = ZERO_WORD;
      endcase
    end
  end

endmodule

// File: rtl/core_alu_arb.sv
// Two-requester front end for a single ALU: arbitrate, latch, execute one
// cycle, then hold the result until the owning requester takes it.
module core_alu_arb
  import core_alu_arb_pkg::*;
#(
  parameter bit FAIR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  word_t      req0_op1,
  input  word_t      req0_op2,
  input  func_t      req0_func,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  word_t      req1_op1,
  input  word_t      req1_op2,
  input  func_t      req1_func,
  output logic       res0_valid,
  input  logic       res0_ready,
  output logic       res1_valid,
  input  logic       res1_ready,
  output word_t      res_data,
  output logic [1:0] fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, ready is only offered in IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t state;
  logic   grant_idx, last_grant, lat_idx, accept, res_take, in_idle;
  word_t  lat_op1, lat_op2, alu_result;
  func_t  lat_func;

  always_comb begin
    if (FAIR_EN) grant_idx = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    else         grant_idx = ~req0_valid;
  end

  // rst_n gates ready so nothing can be accepted while reset is held.
  assign in_idle    = (state == IDLE) & rst_n;
  assign req0_ready = in_idle & req0_valid & ~grant_idx;
  assign req1_ready = in_idle & req1_valid &  grant_idx;
  assign accept     = req0_ready | req1_ready;

  assign res0_valid = (state == RESP) & ~lat_idx;
  assign res1_valid = (state == RESP) &  lat_idx;
  assign res_take   = lat_idx ? res1_ready : res0_ready;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_op1    <= ZERO_WORD;
      lat_op2    <= ZERO_WORD;
      lat_func   <= ALU_ADD;
      lat_idx    <= 1'b0;
      last_grant <= 1'b1;
      res_data   <= ZERO_WORD;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_op1    <= grant_idx ? req1_op1  : req0_op1;
          lat_op2    <= grant_idx ? req1_op2  : req0_op2;
          lat_func   <= grant_idx ? req1_func : req0_func;
          lat_idx    <= grant_idx;
          last_grant <= grant_idx;
          state      <= EXEC;
        end
        EXEC: begin
          res_data <= alu_result;
          state    <= RESP;
        end
        RESP: if (res_take) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  core_alu u_alu (
    .en     ((state == EXEC) ? ALU_ENABLE : ALU_DISABLE),
    .func   (lat_func),
    .op1    (lat_op1),
    .op2    (lat_op2),
    .result (alu_result)
  );

endmodule
